// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response bus of the SLC-3 memory-access sequencer.
// The master is the control FSM / MAR-MDR datapath; the slave is mem_access_ctrl.
interface mem_access_ctrl_if;
  logic        Mem_OE;
  logic        Mem_WE;
  logic [15:0] ADDR;
  logic [15:0] Data_from_CPU;
  logic [15:0] Data_to_CPU;
  logic        Mem_Ready;

  modport master (
    output Mem_OE, Mem_WE, ADDR, Data_from_CPU,
    input  Data_to_CPU, Mem_Ready
  );

  modport slave (
    input  Mem_OE, Mem_WE, ADDR, Data_from_CPU,
    output Data_to_CPU, Mem_Ready
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Turns level-held Mem_OE/Mem_WE requests into fixed-wait-state SRAM cycles with a one-cycle Mem_Ready.
// Optional board I/O at 16'hFFFF (switches / hex register) is enabled by defining SLC3_MMIO_EN.
module mem_access_ctrl #(
  parameter int WAIT_STATES = 2,
  parameter int SRAM_AW     = 20
) (
  input  logic               Clk,
  input  logic               Reset,
  mem_access_ctrl_if.slave   cpu,
  input  logic [15:0]        Switches,
  output logic [15:0]        HEX_Data,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_data_out,
  input  logic [15:0]        sram_data_in,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  localparam int CW = $clog2(WAIT_STATES + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [15:0]   rd_hold_reg, rd_hold_next;

  logic        req;
  logic        in_access;
  logic        is_write;
  logic        active;
  logic        complete;
  logic        mmio_hit;
  logic [15:0] rd_data;

  assign req       = cpu.Mem_OE | cpu.Mem_WE;
  assign in_access = (state_reg == READ) || (state_reg == WRITE);
  // Access type comes from the live request only in cycle 0; afterwards the state holds it.
  assign is_write  = (state_reg == IDLE) ? cpu.Mem_WE : (state_reg == WRITE);
  assign active    = !Reset && req && ((state_reg == IDLE) || in_access);
  assign complete  = active && in_access && (cnt_reg == CW'(WAIT_STATES));

  assign rd_hold_next = (complete && !is_write) ? rd_data : rd_hold_reg;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      rd_hold_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      rd_hold_reg <= rd_hold_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (req) begin
          state_next = cpu.Mem_WE ? WRITE : READ;
          cnt_next   = CW'(1);
        end
      end
      READ, WRITE: begin
        if (!req) begin
          state_next = IDLE;
        end else if (cnt_reg == CW'(WAIT_STATES)) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DONE: begin
        // Wait for the request to drop so a held request cannot re-trigger.
        if (!req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    sram_ce_n       = 1'b1;
    sram_oe_n       = 1'b1;
    sram_we_n       = 1'b1;
    sram_ub_n       = 1'b1;
    sram_lb_n       = 1'b1;
    sram_addr       = SRAM_AW'(cpu.ADDR);
    sram_data_out   = cpu.Data_from_CPU;
    cpu.Mem_Ready   = complete;
    cpu.Data_to_CPU = rd_hold_reg;
    if (active) begin
      sram_ce_n = mmio_hit;
      sram_ub_n = 1'b0;
      sram_lb_n = 1'b0;
      sram_oe_n = is_write;
      sram_we_n = !is_write;
    end
    if (complete && !is_write) cpu.Data_to_CPU = rd_data;
  end

`ifdef SLC3_MMIO_EN
  logic [15:0] hex_reg;

  assign mmio_hit = (cpu.ADDR == 16'hFFFF);
  assign rd_data  = mmio_hit ? Switches : sram_data_in;
  assign HEX_Data = hex_reg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hex_reg <= '0;
    end else if (complete && is_write && mmio_hit) begin
      hex_reg <= cpu.Data_from_CPU;
    end
  end
`else
  logic unused_switches;

  assign mmio_hit        = 1'b0;
  assign rd_data         = sram_data_in;
  assign HEX_Data        = '0;
  assign unused_switches = ^Switches;
`endif

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

- Memory-access sequencer between the SLC-3 control FSM's `Mem_OE`/`Mem_WE` strobes and the off-chip 16-bit SRAM.
- Turns a level-held read/write request into a timed SRAM cycle with a fixed wait-state count and returns read data to the MDR path.
- Raises a one-cycle `Mem_Ready` in the cycle the data is valid or the write completes.
- Optionally maps address 16'hFFFF to board I/O: switches on read, hex-display register on write.

## Interface

Parameters:
- `WAIT_STATES`, default 2: cycles after the request cycle before completion; legal range 1–15. Default matches a 3-cycle held request, with the control FSM loading MDR on the third cycle.
- `SRAM_AW`, default 20: SRAM address width; upper `SRAM_AW-16` bits are driven 0.

Ports:
- `Clk` — in, 1: single clock; all state changes on its rising edge.
- `Reset` — in, 1: synchronous, active-high.
- `Mem_OE` — in, 1: read request, active-high, held for the whole access.
- `Mem_WE` — in, 1: write request, active-high, held for the whole access.
- `ADDR` — in, 16: MAR value, stable while a request is high.
- `Data_from_CPU` — in, 16: MDR value to write.
- `Data_to_CPU` — out, 16: read data to the MDR input mux.
- `Mem_Ready` — out, 1: access completes this cycle.
- `Switches` — in, 16: board switches.
- `HEX_Data` — out, 16: hex-display register.
- `sram_addr` — out, `SRAM_AW`: SRAM address.
- `sram_data_out` — out, 16: write data.
- `sram_data_in` — in, 16: read data.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n` — out, 1 each: active-low SRAM strobes.

## Operation

States:
- `IDLE`: no access in progress.
- `READ`: read cycle under way.
- `WRITE`: write cycle under way.
- `DONE`: access complete; waiting for the request to drop.

Counter `cnt`:
- Width `$clog2(WAIT_STATES+1)`.
- Loaded with 1 on entry to `READ`/`WRITE`; increments each cycle there.

Request cycle 0 = first cycle `Mem_OE|Mem_WE` is high in `IDLE`.
- If `Mem_WE` is high, the access is a write, even when `Mem_OE` is also high.
- Otherwise it is a read.
- `IDLE` goes to `READ` or `WRITE` at the end of cycle 0.

Strobes, combinational from state and request:
- Active in cycle 0 and throughout `READ`/`WRITE` while the request is high. `sram_ce_n=0`, `sram_ub_n=0`, `sram_lb_n=0`.
- Read: `sram_oe_n=0`, `sram_we_n=1`.
- Write: `sram_we_n=0`, `sram_oe_n=1`; `sram_data_out=Data_from_CPU`.
- `sram_addr={0,ADDR}`.
- Otherwise all strobes are 1.

Completion, in the cycle where `cnt==WAIT_STATES`:
- `Mem_Ready=1`.
- Read: `Data_to_CPU=sram_data_in`, passed through combinationally. The same value is captured into `rd_hold` at the clock edge.
- State goes to `DONE`.

Data output outside the completion cycle:
- In every other cycle, `Data_to_CPU=rd_hold`.

`DONE`:
- Strobes inactive.
- Returns to `IDLE` when `Mem_OE` and `Mem_WE` are both 0. This blocks re-triggering on a still-held request.

Early drop (request falls while in `READ`/`WRITE` before completion):
- Strobes deassert in that same cycle.
- Next state `IDLE`.
- No `Mem_Ready`; `rd_hold` and `HEX_Data` unchanged.

Mid-access changes:
- A request switching type (OE to WE) mid-access is ignored; the access type is latched in cycle 0.

## Timing

Reset values:
- State `IDLE`; `rd_hold=0`, so `Data_to_CPU=0`.
- `HEX_Data=0`; `Mem_Ready=0`.
- All SRAM strobes 1; `sram_data_out` don't-care.

Reset timing and priority:
- A reset during any state aborts the access; strobes are inactive from the first cycle `Reset` is high.
- Reset overrides a concurrent request.

Latency:
- `Mem_Ready` is high in cycle `WAIT_STATES`, counted from request cycle 0 (cycle 2 by default).
- Back-to-back accesses need at least one cycle with both requests low, so `DONE` can return to `IDLE`.
- Minimum access period is `WAIT_STATES+2` cycles.

## Configuration

Macro `SLC3_MMIO_EN`.

When defined, address 16'hFFFF is board I/O:
- `sram_ce_n` stays 1 for the access.
- Read returns `Switches`, sampled in the completion cycle.
- Write loads `HEX_Data<=Data_from_CPU` at the end of the completion cycle.
- Timing and `Mem_Ready` are identical to an SRAM access.

When undefined:
- 16'hFFFF is an ordinary SRAM location.
- `HEX_Data` is constant 0.
- `Switches` is unused.

## Test plan

- Read, `WAIT_STATES=2`: `ADDR=16'h0031`, `Mem_OE` held 3 cycles, `sram_data_in=16'h1234` → `sram_oe_n=0` in cycles 0–2; `Mem_Ready=1` only in cycle 2 with `Data_to_CPU=16'h1234`; `Data_to_CPU` stays 16'h1234 after `Mem_OE` drops.
- Write: `ADDR=16'h0040`, `Data_from_CPU=16'hBEEF`, `Mem_WE` held 3 cycles → `sram_we_n=0` and `sram_data_out=16'hBEEF` in cycles 0–2; `Mem_Ready` in cycle 2; `sram_oe_n=1` throughout.
- Held request: `Mem_OE` held 6 cycles → exactly one `Mem_Ready` pulse (cycle 2); strobes inactive in cycles 3–5; a new request after one low cycle starts a fresh access.
- Early drop and reset: `Mem_OE` dropped in cycle 1 → no `Mem_Ready`, strobes inactive that cycle. Separately, `Reset` in cycle 1 of a write → `sram_we_n=1` immediately; `HEX_Data` and `Data_to_CPU` go to 0.
- MMIO (`SLC3_MMIO_EN` defined): write 16'h00A5 to 16'hFFFF → `HEX_Data=16'h00A5`, `sram_ce_n=1`. Then read 16'hFFFF with `Switches=16'h0F0F` → `Data_to_CPU=16'h0F0F` in cycle 2.
- Simultaneous `Mem_OE=Mem_WE=1` at 16'h0010 → performed as a write; `sram_oe_n` never asserted.
